// File: rtl/maze_pkg.sv
// Shared maze encoding: move directions, the run-length token format and the
// FSM state type used by the path compressor.
package maze_pkg;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_UP    = 2'd3
   } dir_e;

   // Run-length field width is shared with the solver side, so it lives here.
   localparam int unsigned LEN_W = 4;
   localparam logic [LEN_W-1:0] RUN_MAX = '1;

   typedef struct packed {
      dir_e             dir;
      logic [LEN_W-1:0] len;
      logic             last;
   } token_t;

   localparam int unsigned TOKEN_W = $bits(token_t);

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } rle_state_e;

   // Opposite directions differ only in bit 1 of the encoding.
   function automatic dir_e reverse_dir(input dir_e d);
      return dir_e'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/rle_token_fifo.sv
// Synchronous token FIFO; a push into a full FIFO is dropped unless a pop
// frees a slot in the same cycle.
module rle_token_fifo #(
   parameter int unsigned WIDTH = 7,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             drop_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_en;
   logic             pop_en;

   // Extra MSB is the wrap bit: equal indices with differing wrap bits means full.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign pop_en  = pop_i && !empty_o;
   assign push_en = push_i && (!full_o || pop_en);
   assign drop_o  = push_i && full_o && !pop_en;

   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   assign wr_ptr_d = push_en ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
   assign rd_ptr_d = pop_en  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers define which entries
   // are valid and data_o is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/maze_path_rle.sv
// Compresses the solver's per-cycle move stream into {dir, len, last} run
// tokens, buffers them for the host and reports path length and path errors.
module maze_path_rle
   import maze_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned STEP_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dir_valid,
   input  logic [1:0]        dir,
   output logic              tok_valid,
   input  logic              tok_ready,
   output logic [1:0]        tok_dir,
   output logic [LEN_W-1:0]  tok_len,
   output logic              tok_last,
   output logic              frame_done,
   output logic [STEP_W-1:0] path_steps,
   output logic              err_overflow,
   output logic              err_reverse
);

   rle_state_e        state_q, state_d;
   dir_e              run_dir_q, run_dir_d;
   logic [LEN_W-1:0]  run_len_q, run_len_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [STEP_W-1:0] path_steps_q, path_steps_d;
   logic              done_q, done_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_rev_q, err_rev_d;
   logic              frame_start;
   logic              push;
   token_t            push_tok;
   token_t            head_tok;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_drop;
   dir_e              dir_in;

   assign dir_in = dir_e'(dir);

   // NOTE: combinational blocks use blocking '=' and assign every output a
   // default first so no path through the case statement can infer a latch.
   always_comb begin
      state_d      = state_q;
      run_dir_d    = run_dir_q;
      run_len_d    = run_len_q;
      step_cnt_d   = step_cnt_q;
      path_steps_d = path_steps_q;
      done_d       = 1'b0;
      err_rev_d    = err_rev_q;
      frame_start  = 1'b0;
      push         = 1'b0;
      push_tok     = '0;

      case (state_q)
         ST_IDLE: begin
            if (dir_valid) begin
               frame_start = 1'b1;
               run_dir_d   = dir_in;
               run_len_d   = LEN_W'(1);
               step_cnt_d  = STEP_W'(1);
               err_rev_d   = 1'b0;
               state_d     = ST_RUN;
            end
         end

         ST_RUN: begin
            if (dir_valid) begin
               if (step_cnt_q != '1) begin
                  step_cnt_d = step_cnt_q + STEP_W'(1);
               end
               if (dir_in == reverse_dir(run_dir_q)) begin
                  err_rev_d = 1'b1;
               end
               if ((dir_in == run_dir_q) && (run_len_q != RUN_MAX)) begin
                  run_len_d = run_len_q + LEN_W'(1);
               end else begin
                  // A full-length run splits into a new run in the same direction.
                  push          = 1'b1;
                  push_tok.dir  = run_dir_q;
                  push_tok.len  = run_len_q;
                  push_tok.last = 1'b0;
                  run_dir_d     = dir_in;
                  run_len_d     = LEN_W'(1);
               end
            end else begin
               push          = 1'b1;
               push_tok.dir  = run_dir_q;
               push_tok.len  = run_len_q;
               push_tok.last = 1'b1;
               path_steps_d  = step_cnt_q;
               done_d        = 1'b1;
               state_d       = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Kept apart from the FSM block: the drop flag depends on the FSM's push.
   always_comb begin
      err_ovf_d = err_ovf_q;
      if (frame_start) begin
         err_ovf_d = 1'b0;
      end
      if (fifo_drop) begin
         err_ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         run_dir_q    <= DIR_RIGHT;
         run_len_q    <= '0;
         step_cnt_q   <= '0;
         path_steps_q <= '0;
         done_q       <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_rev_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_dir_q    <= run_dir_d;
         run_len_q    <= run_len_d;
         step_cnt_q   <= step_cnt_d;
         path_steps_q <= path_steps_d;
         done_q       <= done_d;
         err_ovf_q    <= err_ovf_d;
         err_rev_q    <= err_rev_d;
      end
   end

   rle_token_fifo #(
      .WIDTH (TOKEN_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (push_tok),
      .pop_i   (tok_ready),
      .data_o  (head_tok),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .drop_o  (fifo_drop)
   );

   assign tok_valid    = !fifo_empty;
   assign tok_dir      = head_tok.dir;
   assign tok_len      = head_tok.len;
   assign tok_last     = head_tok.last;
   assign frame_done   = done_q;
   assign path_steps   = path_steps_q;
   assign err_overflow = err_ovf_q;
   assign err_reverse  = err_rev_q;

endmodule
